video_timing_gen: RTL
=====================

# video_timing_gen

Generates the HDMI-side raster: hs, vs and de plus pixel/line counters for NTSC, PAL or mono video. The block is the partner of the front-end analyzer, which measures the incoming core video and emits a one-cycle `vreset` at a fixed point of the visible area. On `vreset` this generator reloads its counters to a programmable position, so the output raster stays phase-locked to the source. It sits between the analyzer and the HDMI encoder, in the pixel clock domain.

## Interface
- `HRST`, default 0: h counter value loaded on `vreset`, range 0..H_TOTAL-1 of every mode.
- `VRST`, default 0: v counter value loaded on `vreset`, range 0..V_TOTAL-1 of every mode.
- `clk` input 1: pixel clock. One clock domain only.
- `resetn` input 1: reset, asynchronous, active-low.
- `mode` input 2: 0=ntsc, 1=pal, 2=mono, 3 treated as mono.
- `vreset` input 1: single-cycle resync pulse from the analyzer.
- `hs` output 1: horizontal sync, active low.
- `vs` output 1: vertical sync, active low.
- `de` output 1: data enable, high in the active area.
- `hcnt` output 10: current pixel counter.
- `vcnt` output 10: current line counter.
- `frame_start` output 1: one-cycle pulse when hcnt=0 and vcnt=0.
- `locked` output 1: high after a `vreset` has been applied in the current mode.
- `resync_cnt` output 8: number of `vreset` loads, saturating at 255.

## Operation
- Timing per mode (total / active / sync start / sync length):
  - NTSC: H 858/720/736/62, V 525/480/489/6.
  - PAL: H 864/720/732/64, V 625/576/581/5.
  - Mono: H 896/640/672/96, V 500/400/425/2.
- Counters:
  - h increments every clock and wraps at H_TOTAL-1 to 0.
  - v increments when h wraps and wraps at V_TOTAL-1 to 0.
- Active mode register `cur_mode`:
  - Samples `mode` only on the last pixel of a frame (h=H_TOTAL-1, v=V_TOTAL-1 of `cur_mode`) or on `vreset`.
  - Mid-frame `mode` changes are ignored until the next such point.
- Mode change: when the newly sampled `mode` differs from `cur_mode`, `locked` clears. The sampled value takes effect on the next cycle.
- `vreset` handling:
  - Next cycle h=HRST and v=VRST, using the newly sampled mode.
  - `locked` is set and `resync_cnt` increments, saturating at 255.
- Simultaneous `vreset` and end-of-frame: `vreset` wins. Counters load HRST/VRST, and the mode is sampled once.
- Output decode:
  - `de` = (h < H_ACTIVE) and (v < V_ACTIVE).
  - `hs` is low for h in [HS_START, HS_START+HS_LEN).
  - `vs` is low for v in [VS_START, VS_START+VS_LEN). It changes at h=0, aligned to line start.
- Widths: counters are 10 bits. All totals are at most 1023. Comparisons are unsigned.

## Timing
- `hs`, `vs`, `de` and `frame_start` are registered from the counters: 1 clock latency relative to `hcnt`/`vcnt`.
- `hcnt`/`vcnt` are the counter registers themselves (0 latency).
- `vreset` sampled at edge N: counters equal HRST/VRST after edge N+1. The decoded outputs for that position appear after edge N+2.
- Reset values (while `resetn`=0):
  - h=0, v=0, `cur_mode`=1 (PAL).
  - `hs`=1, `vs`=1, `de`=0, `frame_start`=0, `locked`=0, `resync_cnt`=0.
- First clock after reset release: counters advance to h=1. The outputs register the position h=0,v=0, giving `de`=1 and `frame_start`=1.
- Reset asserted mid-frame: all state clears immediately. No partial pulses are held.

## Configuration
- `VIDEO_GEN_MONO_EN` defined: mode 2/3 produce the mono timing above.
- Not defined:
  - Mono timing logic is not compiled; mode 2/3 map to PAL timing.
  - A 2→1 transition is not a mode change, so `locked` is kept.

## Test plan
- Reset release, mode=1, no vreset, run 2 frames -> `frame_start` pulses every 540000 clocks; `de` high 720 clocks per line on 576 lines; `hs` low 64 clocks starting at h=732.
- mode=0 from reset -> NTSC takes effect only after the first PAL frame ends. Then 858-clock lines, 525 lines, `vs` low for lines 489..494, and `locked`=0.
- `vreset` at arbitrary position with HRST=100, VRST=5 -> next cycle hcnt=100, vcnt=5; `locked`=1; `resync_cnt`=1; outputs follow one cycle later.
- `vreset` coincident with h=863, v=624 in PAL and mode=0 -> counters load 100/5 and use NTSC limits; one mode sample only; `locked`=1.
- 300 `vreset` pulses -> `resync_cnt` stops at 255; `resetn` low mid-line -> `hs`=1, `vs`=1, `de`=0, `resync_cnt`=0 immediately.
- With `VIDEO_GEN_MONO_EN`, mode=2 -> lines of 896 clocks, 500 lines, `de` 640x400. Without it -> PAL timing, and `locked` is unaffected by 1↔2 switches.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen
// HDMI-side raster generator for NTSC, PAL and mono video. Produces hs/vs/de,
// the pixel/line counters and a frame_start pulse. A one-cycle vreset from the
// front-end analyzer reloads the counters to (HRST, VRST) so the output raster
// stays phase-locked to the source.
// Optional feature: define VIDEO_GEN_MONO_EN to build the mono timing; without
// it, modes 2 and 3 run PAL timing.
// vreset is a bare single-cycle pulse: it is acted on in the cycle it is high,
// there is no valid/ready pairing and no backpressure.
module video_timing_gen #(
    parameter logic [9:0] HRST = 10'd0,
    parameter logic [9:0] VRST = 10'd0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] mode,
    input  logic       vreset,
    output logic       hs,
    output logic       vs,
    output logic       de,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] resync_cnt
);

    localparam logic [1:0] M_NTSC = 2'd0;
    localparam logic [1:0] M_PAL  = 2'd1;
`ifdef VIDEO_GEN_MONO_EN
    localparam logic [1:0] M_MONO = 2'd2;
`endif

    // Active timing mode, held in normalised form so a request that maps to
    // the same timing is never seen as a change.
    logic [1:0] cur_mode;
    logic [1:0] mode_norm;

    // Timing limits of cur_mode; *_end values are exclusive bounds.
    logic [9:0] h_max;
    logic [9:0] h_act;
    logic [9:0] hs_beg;
    logic [9:0] hs_end;
    logic [9:0] v_max;
    logic [9:0] v_act;
    logic [9:0] vs_beg;
    logic [9:0] vs_end;

    logic h_last;
    logic frame_end;

    // Map the requested mode onto the timing it actually selects.
    always_comb begin
        mode_norm = M_PAL;
        case (mode)
            2'd0:    mode_norm = M_NTSC;
            2'd1:    mode_norm = M_PAL;
            default: begin
`ifdef VIDEO_GEN_MONO_EN
                mode_norm = M_MONO;
`else
                mode_norm = M_PAL;
`endif
            end
        endcase
    end

    // Timing table lookup for the active mode (PAL is the fallback).
    always_comb begin
        h_max  = 10'd863;
        h_act  = 10'd720;
        hs_beg = 10'd732;
        hs_end = 10'd796;
        v_max  = 10'd624;
        v_act  = 10'd576;
        vs_beg = 10'd581;
        vs_end = 10'd586;
        case (cur_mode)
            M_NTSC: begin
                h_max  = 10'd857;
                h_act  = 10'd720;
                hs_beg = 10'd736;
                hs_end = 10'd798;
                v_max  = 10'd524;
                v_act  = 10'd480;
                vs_beg = 10'd489;
                vs_end = 10'd495;
            end
`ifdef VIDEO_GEN_MONO_EN
            M_MONO: begin
                h_max  = 10'd895;
                h_act  = 10'd640;
                hs_beg = 10'd672;
                hs_end = 10'd768;
                v_max  = 10'd499;
                v_act  = 10'd400;
                vs_beg = 10'd425;
                vs_end = 10'd427;
            end
`endif
            default: ;
        endcase
    end

    assign h_last    = (hcnt == h_max);
    assign frame_end = h_last && (vcnt == v_max);

    // Raster counters and mode register; vreset takes priority over the
    // end-of-frame wrap, so the mode is sampled exactly once when both coincide.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hcnt     <= 10'd0;
            vcnt     <= 10'd0;
            cur_mode <= M_PAL;
        end else if (vreset) begin
            hcnt     <= HRST;
            vcnt     <= VRST;
            cur_mode <= mode_norm;
        end else if (h_last) begin
            hcnt <= 10'd0;
            if (frame_end) begin
                vcnt     <= 10'd0;
                cur_mode <= mode_norm;
            end else begin
                vcnt <= vcnt + 10'd1;
            end
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    // Lock status and saturating count of resync loads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            locked     <= 1'b0;
            resync_cnt <= 8'd0;
        end else if (vreset) begin
            locked <= 1'b1;
            if (resync_cnt != 8'hff) begin
                resync_cnt <= resync_cnt + 8'd1;
            end
        end else if (frame_end && (mode_norm != cur_mode)) begin
            locked <= 1'b0;
        end
    end

    // Registered decode of the current counter position (one clock behind).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs          <= 1'b1;
            vs          <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            de          <= (hcnt < h_act) && (vcnt < v_act);
            hs          <= !((hcnt >= hs_beg) && (hcnt < hs_end));
            vs          <= !((vcnt >= vs_beg) && (vcnt < vs_end));
            frame_start <= (hcnt == 10'd0) && (vcnt == 10'd0);
        end
    end

endmodule
